phase_sweep_controller: RTL and testbench

//  Sequencer directly upstream of dcm_phaseshift_interface: drives its value_i/load_i to walk the DCM

---
 rtl/phase_sweep_pkg.sv | 15 +
 rtl/phase_sweep_controller_step_calc.sv | 19 +
 rtl/phase_sweep_controller.sv | 101 ++++++++++
 tb/tb_phase_sweep_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_sweep_pkg.sv
// phase_sweep_pkg: shared state encoding, phase width and clamp helper for the phase sweep sequencer.
package phase_sweep_pkg;
    localparam int PHASE_WIDTH = 9;
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_LOW, WAIT_DONE, DWELL, FINISH} state_t;
    // Saturate a one-bit-wider candidate at the sweep end so the last point lands on it exactly.
    function automatic logic signed [PHASE_WIDTH-1:0] clamp_phase(
        input logic signed [PHASE_WIDTH:0]   cand,
        input logic signed [PHASE_WIDTH-1:0] end_p,
        input logic                          up
    );
        logic signed [PHASE_WIDTH:0] e;
        e = {end_p[PHASE_WIDTH-1], end_p};
        return (up ? cand > e : cand < e) ? end_p : cand[PHASE_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/phase_sweep_controller_step_calc.sv
// sweep_step_calc: next sweep target (one step toward the end, clamped) and last-point flag.
module sweep_step_calc
    import phase_sweep_pkg::*;
(
    input  logic signed [PHASE_WIDTH-1:0] target,
    input  logic signed [PHASE_WIDTH-1:0] end_phase,
    input  logic [7:0]                    step,
    input  logic                          up,
    output logic signed [PHASE_WIDTH-1:0] next_phase,
    output logic                          last
);
    logic signed [PHASE_WIDTH:0] wide, mag;
    always_comb begin
        wide = {target[PHASE_WIDTH-1], target};
        mag = (PHASE_WIDTH + 1)'(step);
        next_phase = clamp_phase(up ? wide + mag : wide - mag, end_phase, up);
        last = target == end_phase;
    end
endmodule

// File: rtl/phase_sweep_controller.sv
// phase_sweep_controller: walks the DCM phase from start to end in steps, waiting for each shift
// to settle, dwelling on every point and flagging timeouts or an illegal zero step.
module phase_sweep_controller
    import phase_sweep_pkg::*;
#(
    parameter int PHASE_W = PHASE_WIDTH,
    parameter int DWELL_W = 16,
    parameter int TIMEOUT = 4095
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [PHASE_W-1:0] start_phase_i,
    input  logic [PHASE_W-1:0] end_phase_i,
    input  logic [7:0]         step_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [PHASE_W-1:0] value_o,
    output logic               load_o,
    input  logic               done_i,
    output logic               busy_o,
    output logic               point_o,
    output logic [PHASE_W-1:0] cur_phase_o,
    output logic               sweep_done_o,
    output logic [1:0]         err_o
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = DWELL_W > TW ? DWELL_W : TW;

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [PHASE_W-1:0] end_r, next_phase;
    logic [7:0] step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic up_r, abort_r, zero_done, last;
    logic abort_any, accept, timeout, settle;

    sweep_step_calc u_calc (
        .target(value_o),
        .end_phase(end_r),
        .step(step_r),
        .up(up_r),
        .next_phase(next_phase),
        .last(last)
    );

    assign load_o = state == LOAD;
    assign busy_o = state != IDLE;
    assign sweep_done_o = state == FINISH || zero_done;

    // The shared counter holds the done timeout while waiting and the dwell length while dwelling.
    always_comb begin
        abort_any = abort_r | abort_i;
        accept = state == IDLE && start_i && !abort_i;
        settle = state == WAIT_DONE && done_i;
        timeout = state == WAIT_DONE && !done_i && cnt == '0;
        state_n = state;
        case (state)
            IDLE:      state_n = accept && step_i != '0 ? LOAD : IDLE;
            LOAD:      state_n = WAIT_LOW;
            WAIT_LOW:  state_n = !done_i || cnt != CW'(TIMEOUT - 1) ? WAIT_DONE : WAIT_LOW;
            WAIT_DONE: state_n = done_i ? (abort_any ? FINISH : DWELL) : (cnt == '0 ? FINISH : WAIT_DONE);
            DWELL:     state_n = abort_any || (cnt == '0 && last) ? FINISH : (cnt == '0 ? LOAD : DWELL);
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
            value_o <= '0;
            cur_phase_o <= '0;
            end_r <= '0;
            step_r <= '0;
            dwell_r <= '0;
            up_r <= 1'b0;
            abort_r <= 1'b0;
            zero_done <= 1'b0;
            point_o <= 1'b0;
            err_o <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            zero_done <= accept && step_i == '0;
            point_o <= settle && !abort_any;
            abort_r <= !accept && (abort_r || (abort_i && state != IDLE));
            if (accept) begin
                value_o <= start_phase_i;
                end_r <= end_phase_i;
                step_r <= step_i;
                dwell_r <= dwell_i;
                up_r <= $signed(end_phase_i) >= $signed(start_phase_i);
                err_o <= {step_i == '0, 1'b0};
            end
            if (timeout) err_o[0] <= 1'b1;
            if (settle && !abort_any) cur_phase_o <= value_o;
            if (state == DWELL && state_n == LOAD) value_o <= next_phase;
            cnt <= state == LOAD ? CW'(TIMEOUT - 1) : settle ? CW'(dwell_r) : cnt != '0 ? cnt - CW'(1) : cnt;
        end
    end
endmodule

// File: tb/tb_phase_sweep_controller.sv
// tb_phase_sweep_controller: randomized sweeps against a point-list reference model and a
// behavioural phase-shift interface, checked by a queue scoreboard.
module tb_phase_sweep_controller;
    localparam int TO = 4095;

    logic clk = 0, rst_n = 1, start = 0, abort = 0, done;
    logic [8:0] start_ph = 0, end_ph = 0, value, cur_phase;
    logic [7:0] step = 0;
    logic [15:0] dwell = 0;
    logic load, busy, point, sweep_done;
    logic [1:0] err;

    int checks = 0, errors = 0;
    int exp_load[$], exp_point[$], plan_q[$];
    logic [1:0] exp_done[$];
    int cyc = 0, pt_cyc = -1, cur_dwell = 0;
    int n_done = 0, n_load = 0, n_point = 0, last_load_cyc = 0, done_cyc = 0;
    int lat = 3, busy_cnt = 0, if_phase = 0;
    bit dead = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    phase_sweep_controller #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start), .abort_i(abort),
        .start_phase_i(start_ph), .end_phase_i(end_ph), .step_i(step), .dwell_i(dwell),
        .value_o(value), .load_o(load), .done_i(done), .busy_o(busy), .point_o(point),
        .cur_phase_o(cur_phase), .sweep_done_o(sweep_done), .err_o(err)
    );

    // Interface model: done drops for lat cycles when a load moves the phase; dead never raises it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b1;
            busy_cnt <= 0;
            if_phase <= 0;
        end else if (load) begin
            if (dead || $signed(value) != if_phase) done <= 1'b0;
            busy_cnt <= lat;
            if_phase <= $signed(value);
        end else if (!dead) begin
            if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
            else begin
                busy_cnt <= 0;
                done <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic extra(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an unexpected event, expected none", name);
    endtask

    always @(negedge clk) begin
        if (!rst_n) pt_cyc = -1;
        else begin
            if (load) begin
                last_load_cyc = cyc;
                if (exp_load.size() == 0) extra("load_extra");
                else check("load_value", $signed(value), exp_load.pop_front());
                if (pt_cyc >= 0) check("dwell_gap", cyc - pt_cyc, cur_dwell + 1);
                pt_cyc = -1;
                n_load++;
            end
            if (point) begin
                if (exp_point.size() == 0) extra("point_extra");
                else check("point_phase", $signed(cur_phase), exp_point.pop_front());
                pt_cyc = cyc;
                n_point++;
            end
            if (sweep_done) begin
                done_cyc = cyc;
                if (exp_done.size() == 0) extra("sweep_done_extra");
                else check("sweep_err", err, exp_done.pop_front());
                pt_cyc = -1;
                n_done++;
            end
        end
    end

    // Reference: every visited phase from s toward e, last one saturated at e.
    function automatic void gen(input int s, input int e, input int st);
        int p = s;
        plan_q.delete();
        plan_q.push_back(p);
        while (p != e) begin
            if (e >= s) p = (p + st > e) ? e : p + st;
            else p = (p - st < e) ? e : p - st;
            plan_q.push_back(p);
        end
    endfunction

    task automatic kick(input int s, input int e, input int st, input int dw, input bit ab);
        @(negedge clk);
        start_ph = 9'(s);
        end_ph = 9'(e);
        step = 8'(st);
        dwell = 16'(dw);
        start = 1;
        abort = ab;
        @(negedge clk);
        start = 0;
        abort = 0;
    endtask

    task automatic wait_done(input int n0, input int budget);
        for (int i = 0; i < budget && n_done == n0; i++) @(negedge clk);
        check("sweep_done_seen", int'(n_done != n0), 1);
        @(negedge clk);
    endtask

    task automatic check_empty();
        check("queues_empty", exp_load.size() + exp_point.size() + exp_done.size(), 0);
        check("busy_after", busy, 0);
    endtask

    task automatic run(input int s, input int e, input int st, input int dw, input int l);
        int n0 = n_done;
        lat = l;
        cur_dwell = dw;
        gen(s, e, st);
        foreach (plan_q[i]) begin
            exp_load.push_back(plan_q[i]);
            exp_point.push_back(plan_q[i]);
        end
        exp_done.push_back(2'b00);
        kick(s, e, st, dw, 0);
        wait_done(n0, plan_q.size() * (dw + 20) + 50);
        check_empty();
        check("value_hold", $signed(value), e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_value"}, value, 0);
        check({tag, "_load"}, load, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_point"}, point, 0);
        check({tag, "_cur_phase"}, cur_phase, 0);
        check({tag, "_sweep_done"}, sweep_done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int n0, nl, s, e;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1;

        run(0, 20, 5, 3, 3);
        run(10, -7, 8, 2, 4);
        repeat (8) begin
            s = int'($urandom_range(0, 511)) - 256;
            e = int'($urandom_range(0, 511)) - 256;
            run(s, e, int'($urandom_range(8, 255)), int'($urandom_range(0, 5)), int'($urandom_range(1, 6)));
        end

        // Zero step: no load, error flag, immediate done pulse.
        exp_done.push_back(2'b10);
        n0 = n_done;
        kick(5, 30, 0, 1, 0);
        wait_done(n0, 20);
        check_empty();

        // Start together with abort in idle is ignored.
        nl = n_load;
        kick(0, 50, 10, 1, 1);
        check("start_abort_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("start_abort_loads", n_load - nl, 0);

        // Interface never settles: one load, then timeout; a start while busy is ignored.
        s = int'($urandom_range(0, 200)) - 100;
        dead = 1;
        exp_load.push_back(s);
        exp_done.push_back(2'b01);
        n0 = n_done;
        kick(s, s + 40, 10, 0, 0);
        repeat (10) @(negedge clk);
        kick(0, 10, 1, 0, 0);
        wait_done(n0, TO + 100);
        check_empty();
        checks++;
        if (done_cyc - last_load_cyc < TO || done_cyc - last_load_cyc > TO + 3) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected %0d..%0d", done_cyc - last_load_cyc, TO, TO + 3);
        end
        dead = 0;
        repeat (10) @(negedge clk);
        run(-30, 30, 20, 1, 2);

        // Abort while the second shift is in flight.
        gen(-50, 50, 30);
        lat = 5;
        cur_dwell = 2;
        exp_load.push_back(plan_q[0]);
        exp_load.push_back(plan_q[1]);
        exp_point.push_back(plan_q[0]);
        exp_done.push_back(2'b00);
        n0 = n_done;
        nl = n_load;
        kick(-50, 50, 30, 2, 0);
        for (int i = 0; i < 200 && n_load < nl + 2; i++) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        wait_done(n0, 200);
        check_empty();
        check("abort_loads", n_load - nl, 2);

        // Reset in the middle of a dwell, then a single-point sweep.
        gen(0, 100, 25);
        lat = 2;
        cur_dwell = 20;
        foreach (plan_q[i]) begin
            exp_load.push_back(plan_q[i]);
            exp_point.push_back(plan_q[i]);
        end
        nl = n_point;
        kick(0, 100, 25, 20, 0);
        for (int i = 0; i < 200 && n_point == nl; i++) @(negedge clk);
        check("reset_point_seen", int'(n_point != nl), 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1 check_zero("midreset");
        exp_load.delete();
        exp_point.delete();
        exp_done.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        run(0, 0, int'($urandom_range(1, 255)), 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
